// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: command modes, FSM states and per-phase patterns.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'b00,
        MODE_SOLID = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_ALT   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN_A = 2'b01,
        ST_RUN_B = 2'b10
    } state_e;

    localparam int unsigned PAT_W = 2;

    localparam logic [PAT_W-1:0] PAT_OFF     = 2'b00;
    localparam logic [PAT_W-1:0] PAT_A_SOLID = 2'b11;
    localparam logic [PAT_W-1:0] PAT_B_SOLID = 2'b11;
    localparam logic [PAT_W-1:0] PAT_A_BLINK = 2'b11;
    localparam logic [PAT_W-1:0] PAT_B_BLINK = 2'b00;
    localparam logic [PAT_W-1:0] PAT_A_ALT   = 2'b01;
    localparam logic [PAT_W-1:0] PAT_B_ALT   = 2'b10;

    // Base 2-bit pattern for a given state and latched mode; IDLE is always dark.
    function automatic logic [PAT_W-1:0] pattern(input state_e st, input mode_e m);
        logic [PAT_W-1:0] p;
        logic             is_a;
        p    = PAT_OFF;
        is_a = (st == ST_RUN_A);
        case (m)
            MODE_SOLID: p = is_a ? PAT_A_SOLID : PAT_B_SOLID;
            MODE_BLINK: p = is_a ? PAT_A_BLINK : PAT_B_BLINK;
            MODE_ALT:   p = is_a ? PAT_A_ALT   : PAT_B_ALT;
            default:    p = PAT_OFF;
        endcase
        if (st == ST_IDLE) begin
            p = PAT_OFF;
        end
        return p;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Dwell-tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick_c on the last count.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;

    assign tick_c = en && (presc_q == PRE_TOP);

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Commandable two-phase LED pattern scheduler with millisecond dwell timing.
// Optional PWM dimming via duty[3:0] when LED_PWM_EN is defined.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DWELL_W  = 16,
    parameter int unsigned LED_W    = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               mode_valid,
    output logic               mode_ready,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [LED_W-1:0]   led,
    output logic               busy,
    output logic               phase
`ifdef LED_PWM_EN
    ,
    input  logic [3:0]         duty
`endif
);

    localparam int unsigned REP = (LED_W + 1) / 2;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               busy_q, busy_d;
    logic               phase_q, phase_d;

    logic               run_c;
    logic               tick_c;
    logic               phase_end_c;
    logic               accept_c;
    logic               clr_c;
    logic [PAT_W-1:0]   pat_c;
    logic [2*REP-1:0]   pat_rep_c;

`ifdef LED_PWM_EN
    logic [3:0]         pwm_cnt_q, pwm_cnt_d;
`endif

    assign run_c       = (state_q != ST_IDLE);
    assign phase_end_c = tick_c && (dwell_cnt_q == dwell_q - DWELL_W'(1));
    // Commands are only taken when idle or on the last cycle of a full A/B period.
    assign mode_ready  = (state_q == ST_IDLE) || ((state_q == ST_RUN_B) && phase_end_c);
    assign accept_c    = mode_valid && mode_ready;
    assign clr_c       = accept_c || phase_end_c;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .en     (run_c),
        .clr    (clr_c),
        .tick_c (tick_c)
    );

    // Next-state, dwell counting and registered-output precompute.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;

        if (tick_c) begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
        if (phase_end_c) begin
            dwell_cnt_d = '0;
            state_d     = (state_q == ST_RUN_A) ? ST_RUN_B : ST_RUN_A;
        end
        if (accept_c) begin
            mode_d      = mode_e'(mode);
            dwell_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
            dwell_cnt_d = '0;
            state_d     = (mode_e'(mode) == MODE_STOP) ? ST_IDLE : ST_RUN_A;
        end

        pat_c     = pattern(state_d, mode_d);
        pat_rep_c = {REP{pat_c}};
        led_d     = pat_rep_c[LED_W-1:0];
`ifdef LED_PWM_EN
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        led_d     = led_d & {LED_W{pwm_cnt_q < duty}};
`endif
        busy_d    = (state_d != ST_IDLE);
        phase_d   = (state_d == ST_RUN_B);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_STOP;
            dwell_q     <= DWELL_W'(1);
            dwell_cnt_q <= '0;
            led_q       <= '0;
            busy_q      <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            phase_q     <= phase_d;
        end
    end

`ifdef LED_PWM_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`endif

    assign led   = led_q;
    assign busy  = busy_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4: segment table plus hand-written corner sequences.
module tb_led_seq_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DWELL_W  = 16;
    localparam int unsigned LED_W    = 2;

    logic               sys_clk;
    logic               sys_rst_n;
    logic               mode_valid;
    logic               mode_ready;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic [LED_W-1:0]   led;
    logic               busy;
    logic               phase;
`ifdef LED_PWM_EN
    logic [3:0]         duty;
`endif

    int nvec = 0;
    int nbad = 0;

    led_seq_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DWELL_W  (DWELL_W),
        .LED_W    (LED_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .mode       (mode),
        .dwell      (dwell),
        .led        (led),
        .busy       (busy),
        .phase      (phase)
`ifdef LED_PWM_EN
        ,
        .duty       (duty)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // One segment: drive a command (or nothing), then expect n cycles of constant outputs.
    typedef struct {
        logic               valid;
        logic [1:0]         mode;
        logic [DWELL_W-1:0] dwell;
        int                 n;
        logic [1:0]         exp_led;
        logic               exp_busy;
        logic               exp_phase;
        logic               rdy_last;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // With PWM dimming the bank may be blanked for a cycle; otherwise it must match exactly.
    task automatic chk_led(input string name, input logic [1:0] exp);
        nvec++;
`ifdef LED_PWM_EN
        if (!((led === exp) || (led === 2'b00))) begin
`else
        if (led !== exp) begin
`endif
            nbad++;
            $display("FAIL %s: led got %b expected %b at %0t", name, led, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] e_led, input logic e_busy,
                           input logic e_phase, input logic e_rdy);
        chk_led(name, e_led);
        chk({name, ".busy"},  32'(busy),       32'(e_busy));
        chk({name, ".phase"}, 32'(phase),      32'(e_phase));
        chk({name, ".ready"}, 32'(mode_ready), 32'(e_rdy));
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'b00, 16'd0, 5,  2'b00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 2'b11, 16'd3, 12, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b11, 16'd3, 12, 2'b10, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 2'b11, 16'd3, 12, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b11, 16'd3, 12, 2'b10, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 2'b00, 16'd5, 3,  2'b00, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'b01, 16'd0, 4,  2'b11, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'b01, 16'd0, 4,  2'b11, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 2'b01, 16'd0, 4,  2'b11, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b01, 16'd0, 4,  2'b11, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 2'b10, 16'd2, 8,  2'b11, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'b10, 16'd2, 8,  2'b00, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 2'b10, 16'd2, 3,  2'b11, 1'b1, 1'b0, 1'b0};

        sys_rst_n  = 1'b0;
        mode_valid = 1'b0;
        mode       = 2'b00;
        dwell      = '0;
`ifdef LED_PWM_EN
        duty       = 4'd15;
`endif
        #100;
        chk_all("in_reset", 2'b00, 1'b0, 1'b0, 1'b1);
        #100;
        sys_rst_n = 1'b1;
        step();

        for (int s = 0; s < 13; s++) begin
            mode_valid = tbl[s].valid;
            mode       = tbl[s].mode;
            dwell      = tbl[s].dwell;
            for (int k = 0; k < tbl[s].n; k++) begin
                step();
                mode_valid = 1'b0;
                chk_all($sformatf("seg%0d.c%0d", s, k), tbl[s].exp_led, tbl[s].exp_busy,
                        tbl[s].exp_phase,
                        (k == tbl[s].n - 1) ? tbl[s].rdy_last : !tbl[s].exp_busy);
            end
        end

        // BLINK dwell=2 at A cycle 3; SOLID dwell=1 held until the period boundary.
        mode_valid = 1'b1;
        mode       = 2'b01;
        dwell      = 16'd1;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk_all($sformatf("wait.c%0d", k), (k <= 5) ? 2'b11 : 2'b00, 1'b1,
                    (k > 5), (k == 13));
        end
        step();
        mode_valid = 1'b0;
        chk_all("solid.a1", 2'b11, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 7; j++) begin
            step();
            chk_all($sformatf("solid.c%0d", j), 2'b11, 1'b1, (j >= 4), (j == 7));
        end
        step();
        chk_all("solid.again_a1", 2'b11, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-phase-A.
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("post_rst.c%0d", k), 2'b00, 1'b0, 1'b0, 1'b1);
        end

`ifdef LED_PWM_EN
        begin
            int on_cnt;
            duty       = 4'd4;
            mode_valid = 1'b1;
            mode       = 2'b01;
            dwell      = 16'd1;
            step();
            mode_valid = 1'b0;
            on_cnt = 0;
            for (int k = 0; k < 32; k++) begin
                if (led === 2'b11) on_cnt++;
                step();
            end
            chk("pwm_duty4_on", 32'(on_cnt), 32'd8);
            duty = 4'd0;
            step();
            on_cnt = 0;
            for (int k = 0; k < 32; k++) begin
                if (led !== 2'b00) on_cnt++;
                step();
            end
            chk("pwm_duty0_on", 32'(on_cnt), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
